// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU operation selects and datapath mux encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_RTYPE    = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_EXCEPT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

endpackage

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: decodes every datapath control line from the
// state register, with optional memory-ready stalls and an exception path.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int EXC_EN   = 1,
  parameter int ALUOP_W  = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               EPCWrite,
  output logic               CauseWrite,
  output logic [3:0]         State
);

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic       rdy;

  assign rdy   = MemReady | (MEM_WAIT == 0);
  assign State = state_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     state_next = S_RTYPE;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EX;
          default:      state_next = (EXC_EN != 0) ? S_EXCEPT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = rdy ? S_FETCH : S_MEMWRITE;
      S_RTYPE:    state_next = S_RTYPE_WB;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_W'(ALU_ADD);
    PCSource    = PCSRC_ALU;
    EPCWrite    = 1'b0;
    CauseWrite  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // Instruction fetch and PC+4 commit only once memory has delivered.
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = rdy;
        PCWrite = rdy;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH2;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(ALU_FUNCT);
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(ALU_SUB);
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDI_WB:  RegWrite = 1'b1;
      S_EXCEPT: begin
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        PCWrite    = 1'b1;
        PCSource   = PCSRC_EXC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized check of mc_control_unit against an instruction-level model that
// expands each opcode into its list of control steps and expected latency.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] op;
  logic       mem_ready;

  logic       pcw_a, pcwc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rdst_a, rw_a, srca_a, epc_a, cause_a;
  logic [1:0] srcb_a, pcs_a;
  logic [2:0] aluop_a;
  logic [3:0] st_a;
  logic       pcw_b, pcwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rdst_b, rw_b, srca_b, epc_b, cause_b;
  logic [1:0] srcb_b, pcs_b;
  logic [2:0] aluop_b;
  logic [3:0] st_b;

  logic [18:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pcw_a, pcwc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rdst_a, rw_a, srca_a,
                   srcb_a, aluop_a, pcs_a, epc_a, cause_a};
  assign ctrl_b = {pcw_b, pcwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rdst_b, rw_b, srca_b,
                   srcb_b, aluop_b, pcs_b, epc_b, cause_b};

  always #5 Clk = ~Clk;

  mc_control_unit #(.MEM_WAIT(1), .EXC_EN(1), .ALUOP_W(3)) dut_a (
    .Clk(Clk), .Reset(rst_a), .Op(op), .MemReady(mem_ready),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mr_a), .MemWrite(mw_a),
    .IRWrite(irw_a), .MemtoReg(m2r_a), .RegDst(rdst_a), .RegWrite(rw_a), .ALUSrcA(srca_a),
    .ALUSrcB(srcb_a), .ALUOp(aluop_a), .PCSource(pcs_a), .EPCWrite(epc_a),
    .CauseWrite(cause_a), .State(st_a)
  );

  mc_control_unit #(.MEM_WAIT(0), .EXC_EN(0), .ALUOP_W(3)) dut_b (
    .Clk(Clk), .Reset(rst_b), .Op(op), .MemReady(mem_ready),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mr_b), .MemWrite(mw_b),
    .IRWrite(irw_b), .MemtoReg(m2r_b), .RegDst(rdst_b), .RegWrite(rw_b), .ALUSrcA(srca_b),
    .ALUSrcB(srcb_b), .ALUOp(aluop_b), .PCSource(pcs_b), .EPCWrite(epc_b),
    .CauseWrite(cause_b), .State(st_b)
  );

  int         checks = 0;
  int         errors = 0;
  state_t     q[$];
  logic [5:0] cur_op;
  logic [5:0] pool [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h01, 6'h05, 6'h2A};
  bit         m_exc, m_wait, dsel;
  int         n_instr, instr_cycles, waits;

  // Control lines each step must show, straight from the operation table.
  function automatic logic [18:0] exp_ctrl(input state_t ph, input bit rdy);
    bit pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rdst = 0, rw = 0;
    bit srca = 0, epc = 0, cause = 0;
    logic [1:0] srcb = 2'b00, pcs = 2'b00;
    logic [2:0] aluop = 3'b000;
    case (ph)
      S_FETCH:    begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   srcb = 2'b11;
      S_MEMADR:   begin srca = 1; srcb = 2'b10; end
      S_MEMREAD:  begin iord = 1; mr = 1; end
      S_MEMWB:    begin rw = 1; m2r = 1; end
      S_MEMWRITE: begin iord = 1; mw = 1; end
      S_RTYPE:    begin srca = 1; aluop = 3'b010; end
      S_RTYPE_WB: begin rw = 1; rdst = 1; end
      S_BRANCH:   begin srca = 1; aluop = 3'b001; pcwc = 1; pcs = 2'b01; end
      S_JUMP:     begin pcw = 1; pcs = 2'b10; end
      S_ADDI_EX:  begin srca = 1; srcb = 2'b10; end
      S_ADDI_WB:  rw = 1;
      S_EXCEPT:   begin epc = 1; cause = 1; pcw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcs, epc, cause};
  endfunction

  function automatic int latency(input logic [5:0] o, input bit exc);
    case (o)
      6'h00, 6'h2B, 6'h08: return 4;
      6'h23:               return 5;
      6'h04, 6'h02:        return 3;
      default:             return exc ? 3 : 2;
    endcase
  endfunction

  task automatic start_instr();
    cur_op = (n_instr < 10) ? pool[n_instr] : pool[$urandom_range(0, 9)];
    n_instr++;
    instr_cycles = 0;
    waits = 0;
    q.delete();
    q.push_back(S_FETCH);
    q.push_back(S_DECODE);
    case (cur_op)
      6'h00: begin q.push_back(S_RTYPE); q.push_back(S_RTYPE_WB); end
      6'h23: begin q.push_back(S_MEMADR); q.push_back(S_MEMREAD); q.push_back(S_MEMWB); end
      6'h2B: begin q.push_back(S_MEMADR); q.push_back(S_MEMWRITE); end
      6'h04: q.push_back(S_BRANCH);
      6'h02: q.push_back(S_JUMP);
      6'h08: begin q.push_back(S_ADDI_EX); q.push_back(S_ADDI_WB); end
      default: if (m_exc) q.push_back(S_EXCEPT);
    endcase
  endtask

  task automatic check_now(input string tag);
    logic [22:0] obs, exp;
    bit rdy;
    rdy = mem_ready | !m_wait;
    obs = dsel ? {st_b, ctrl_b} : {st_a, ctrl_a};
    exp = {4'(q[0]), exp_ctrl(q[0], rdy)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%s op=%02h state/ctrl observed=%h expected=%h",
             tag, q[0].name(), cur_op, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    #1;
    if (dsel) rst_b = 1'b0; else rst_a = 1'b0;
    start_instr();
    #1 check_now("reset_async");
    #1;
    if (dsel) rst_b = 1'b1; else rst_a = 1'b1;
    $display("reset pulse mid-instruction, model restarted at FETCH");
  endtask

  task automatic advance();
    bit rdy;
    rdy = mem_ready | !m_wait;
    instr_cycles++;
    if ((q[0] == S_FETCH || q[0] == S_MEMREAD || q[0] == S_MEMWRITE) && !rdy) begin
      waits++;
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        checks++;
        assert (instr_cycles == latency(cur_op, m_exc) + waits) else begin
          errors++;
          $error("FAIL latency op=%02h observed=%0d expected=%0d",
                 cur_op, instr_cycles, latency(cur_op, m_exc) + waits);
        end
        $display("instr op=%02h cycles=%0d waits=%0d", cur_op, instr_cycles, waits);
        start_instr();
      end
    end
  endtask

  task automatic run(input bit sel, input bit exc, input bit w, input int ncycles);
    dsel = sel;
    m_exc = exc;
    m_wait = w;
    n_instr = 0;
    @(negedge Clk);
    start_instr();
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    for (int c = 0; c < ncycles; c++) begin
      mem_ready = ($urandom_range(0, 99) < 65);
      // Real opcode only where it is sampled; garbage elsewhere must be ignored.
      op = (q[0] == S_DECODE || q[0] == S_MEMADR) ? cur_op : 6'($urandom_range(0, 63));
      #1 check_now("cycle");
      if ((q[0] == S_RTYPE || q[0] == S_MEMREAD) && $urandom_range(0, 3) == 0) reset_pulse();
      @(posedge Clk);
      advance();
      @(negedge Clk);
    end
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    op = 6'h00;
    mem_ready = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    assert ({st_a, ctrl_a} === {4'(S_FETCH), exp_ctrl(S_FETCH, 1'b0)}) else begin
      errors++;
      $error("FAIL reset_a observed=%h expected=%h", {st_a, ctrl_a},
             {4'(S_FETCH), exp_ctrl(S_FETCH, 1'b0)});
    end
    checks++;
    assert ({st_b, ctrl_b} === {4'(S_FETCH), exp_ctrl(S_FETCH, 1'b1)}) else begin
      errors++;
      $error("FAIL reset_b observed=%h expected=%h", {st_b, ctrl_b},
             {4'(S_FETCH), exp_ctrl(S_FETCH, 1'b1)});
    end
    run(1'b0, 1'b1, 1'b1, 900);
    run(1'b1, 1'b0, 1'b0, 600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
